// File: rtl/bsg_fsb_egress_credit_buffer.sv
// FIFO-buffered, credit-flow-controlled egress stage for the FSB ring.
// Optional statistics counters are enabled with `define BSG_FSB_EGRESS_STATS_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_fsb_egress_credit_buffer #(
  parameter int ring_width_p     = 80,
  parameter int els_p            = 4,
  parameter int remote_credits_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    yumi_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    ready_i,
  input  logic                    credit_i,
`ifdef BSG_FSB_EGRESS_STATS_EN
  output logic [31:0]             sent_count_o,
  output logic [31:0]             credit_stall_o,
`endif
  output logic                    credit_overflow_o
);

  localparam int ptr_w_lp    = `BSG_SAFE_CLOG2(els_p);
  localparam int occ_w_lp    = `BSG_SAFE_CLOG2(els_p + 1);
  localparam int credit_w_lp = `BSG_SAFE_CLOG2(remote_credits_p + 1);

  localparam logic [ptr_w_lp-1:0]    last_ptr_lp    = ptr_w_lp'(els_p - 1);
  localparam logic [occ_w_lp-1:0]    full_occ_lp    = occ_w_lp'(els_p);
  localparam logic [credit_w_lp-1:0] max_credits_lp = credit_w_lp'(remote_credits_p);

  logic [ring_width_p-1:0] mem_r [els_p];
  logic [ptr_w_lp-1:0]     rptr_r, wptr_r;
  logic [occ_w_lp-1:0]     occ_r;
  logic [credit_w_lp-1:0]  credits_r;
  logic                    empty, full, send, no_credits;

  assign empty      = (occ_r == '0);
  assign full       = (occ_r == full_occ_lp);
  assign no_credits = (credits_r == '0);

  // Enqueue decision never looks at ready_i, so there is no ring-to-client path.
  assign yumi_o = v_i & en_i & ~full & ~reset_i;
  assign v_o    = ~empty & ~no_credits & ~reset_i;
  assign data_o = mem_r[rptr_r];
  assign send   = v_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (yumi_o) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      occ_r  <= '0;
    end else begin
      if (yumi_o) wptr_r <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;
      if (send)   rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
      if (yumi_o & ~send)      occ_r <= occ_r + 1'b1;
      else if (~yumi_o & send) occ_r <= occ_r - 1'b1;
    end
  end

  // A credit returned while already at the maximum saturates and latches an error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_r         <= max_credits_lp;
      credit_overflow_o <= 1'b0;
    end else if (credit_i & ~send) begin
      if (credits_r == max_credits_lp) credit_overflow_o <= 1'b1;
      else                             credits_r <= credits_r + 1'b1;
    end else if (send & ~credit_i) begin
      credits_r <= credits_r - 1'b1;
    end
  end

`ifdef BSG_FSB_EGRESS_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sent_count_o   <= '0;
      credit_stall_o <= '0;
    end else begin
      if (send)                sent_count_o   <= sent_count_o + 32'd1;
      if (~empty & no_credits) credit_stall_o <= credit_stall_o + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  if (remote_credits_p < 1 || els_p < 2) begin : g_bad_params
    $error("bsg_fsb_egress_credit_buffer: remote_credits_p must be >= 1 and els_p >= 2");
  end

  assert property (@(posedge clk_i) disable iff (reset_i) (v_o && !ready_i) |=> v_o)
    else $error("bsg_fsb_egress_credit_buffer: v_o dropped without a send");
`endif

endmodule

// File: tb/tb_bsg_fsb_egress_credit_buffer.sv
// Directed self-checking bench for bsg_fsb_egress_credit_buffer (80-bit, 4 deep, 2 credits).
// Honours `define BSG_FSB_EGRESS_STATS_EN to also check the statistics outputs.
module tb_bsg_fsb_egress_credit_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i, en_i, v_i, ready_i, credit_i;
  logic [79:0] data_i;
  logic        yumi_o, v_o, credit_overflow_o;
  logic [79:0] data_o;
`ifdef BSG_FSB_EGRESS_STATS_EN
  logic [31:0] sent_count_o, credit_stall_o;
`endif

  int checkCount = 0;
  int passCount  = 0;

  bsg_fsb_egress_credit_buffer #(
    .ring_width_p(80), .els_p(4), .remote_credits_p(2)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
    .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
    .credit_i(credit_i),
`ifdef BSG_FSB_EGRESS_STATS_EN
    .sent_count_o(sent_count_o), .credit_stall_o(credit_stall_o),
`endif
    .credit_overflow_o(credit_overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [79:0] actual, input logic [79:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Drive one cycle's inputs shortly after the rising edge, then settle.
  task automatic applyStimulus(input logic v, input logic [79:0] d, input logic en,
                               input logic rdy, input logic cr, input logic rst);
    v_i = v; data_i = d; en_i = en; ready_i = rdy; credit_i = cr; reset_i = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    applyStimulus(1, 80'h77, 1, 0, 0, 1);
    checkOutput("reset_v_o", v_o, 0);
    checkOutput("reset_yumi", yumi_o, 0);
    tick(); tick();

    // Single packet: accepted same cycle, visible next cycle, one credit spent.
    applyStimulus(1, 80'h1, 1, 0, 0, 0);
    checkOutput("t1_yumi", yumi_o, 1);
    checkOutput("t1_v_empty", v_o, 0);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 0, 0);
    checkOutput("t1_v_o", v_o, 1);
    checkOutput("t1_data", data_o, 80'h1);
    tick();
    applyStimulus(0, 80'h0, 1, 0, 1, 0);
    checkOutput("t1_drained", v_o, 0);
    tick();

    // Credits back at 2: A,B go out, C stalls until one credit returns.
    applyStimulus(1, 80'hA, 1, 1, 0, 0);
    checkOutput("t2_v_empty", v_o, 0);
    tick();
    applyStimulus(1, 80'hB, 1, 1, 0, 0);
    checkOutput("t2_data_A", data_o, 80'hA);
    checkOutput("t2_v_A", v_o, 1);
    tick();
    applyStimulus(1, 80'hC, 1, 1, 0, 0);
    checkOutput("t2_data_B", data_o, 80'hB);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 0, 0);
    checkOutput("t2_stall0", v_o, 0);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 1, 0);
    checkOutput("t2_stall1", v_o, 0);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 0, 0);
    checkOutput("t2_v_C", v_o, 1);
    checkOutput("t2_data_C", data_o, 80'hC);
`ifdef BSG_FSB_EGRESS_STATS_EN
    checkOutput("t2_stall_count", 80'(credit_stall_o), 80'd2);
`endif
    tick();
`ifdef BSG_FSB_EGRESS_STATS_EN
    checkOutput("t2_sent_count", 80'(sent_count_o), 80'd4);
`endif
    applyStimulus(0, 80'h0, 1, 0, 1, 0);
    tick();
    applyStimulus(0, 80'h0, 1, 0, 1, 0);
    tick();

    // Fill to 4 with ready low; the fifth push must be refused.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 80'h10 + 80'(i), 1, 0, 0, 0);
      checkOutput($sformatf("t3_yumi%0d", i), yumi_o, (i < 4) ? 1'b1 : 1'b0);
      if (i < 4) tick();
    end
    applyStimulus(1, 80'h14, 1, 1, 0, 0);
    checkOutput("t3_full_deq_yumi", yumi_o, 0);
    checkOutput("t3_data0", data_o, 80'h10);
    tick();
    // Remaining three sends each paired with a credit: count holds at 1.
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 80'h0, 1, 1, 1, 0);
      checkOutput($sformatf("t3_v%0d", i), v_o, 1);
      checkOutput($sformatf("t3_data%0d", i), data_o, 80'h10 + 80'(i));
      tick();
    end
    applyStimulus(0, 80'h0, 1, 0, 0, 0);
    checkOutput("t3_empty", v_o, 0);

    // Exactly one credit left: 0x20 goes, 0x21 waits for a credit.
    applyStimulus(1, 80'h20, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 80'h21, 1, 1, 0, 0);
    checkOutput("t4_data20", data_o, 80'h20);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 1, 0);
    checkOutput("t4_one_credit", v_o, 0);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 0, 0);
    checkOutput("t4_data21", data_o, 80'h21);
    checkOutput("t4_v21", v_o, 1);
    tick();
    applyStimulus(0, 80'h0, 1, 0, 1, 0);
    tick();
    applyStimulus(0, 80'h0, 1, 0, 1, 0);
    checkOutput("t5_ovf_clear", credit_overflow_o, 0);
    tick();

    // Extra credit at the maximum: overflow latches and counter saturates at 2.
    applyStimulus(0, 80'h0, 1, 0, 1, 0);
    tick();
    applyStimulus(0, 80'h0, 1, 0, 0, 0);
    checkOutput("t5_ovf_set", credit_overflow_o, 1);
    tick(); tick();
    checkOutput("t5_ovf_sticky", credit_overflow_o, 1);
    applyStimulus(1, 80'h30, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 80'h31, 1, 1, 0, 0);
    checkOutput("t5_data30", data_o, 80'h30);
    tick();
    applyStimulus(1, 80'h32, 1, 1, 0, 0);
    checkOutput("t5_data31", data_o, 80'h31);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 0, 0);
    checkOutput("t5_saturated", v_o, 0);
    tick();

    // en_i low: nothing accepted, queued packets still drain.
    applyStimulus(0, 80'h0, 1, 0, 1, 0);
    tick();
    applyStimulus(1, 80'h33, 1, 0, 0, 0);
    checkOutput("t6_yumi_en", yumi_o, 1);
    checkOutput("t6_head", data_o, 80'h32);
    tick();
    applyStimulus(1, 80'h99, 0, 0, 1, 0);
    checkOutput("t6_yumi_off0", yumi_o, 0);
    tick();
    applyStimulus(1, 80'h99, 0, 1, 0, 0);
    checkOutput("t6_yumi_off1", yumi_o, 0);
    checkOutput("t6_data32", data_o, 80'h32);
    tick();
    applyStimulus(1, 80'h99, 0, 1, 0, 0);
    checkOutput("t6_v33", v_o, 1);
    checkOutput("t6_data33", data_o, 80'h33);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 0, 0);
    checkOutput("t6_done", v_o, 0);
    checkOutput("t6_ovf_sticky", credit_overflow_o, 1);
    tick();

    // Reset with three packets queued: all discarded, credits back to 2.
    applyStimulus(0, 80'h0, 1, 0, 1, 0);
    tick();
    applyStimulus(0, 80'h0, 1, 0, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 80'h40 + 80'(i), 1, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 80'h0, 1, 0, 0, 0);
    checkOutput("t7_pre_data", data_o, 80'h40);
    applyStimulus(1, 80'h0, 1, 0, 1, 1);
    checkOutput("t7_rst_v", v_o, 0);
    checkOutput("t7_rst_yumi", yumi_o, 0);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 0, 0);
    checkOutput("t7_post_v", v_o, 0);
    checkOutput("t7_post_ovf", credit_overflow_o, 0);
    applyStimulus(1, 80'h50, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 80'h51, 1, 1, 0, 0);
    checkOutput("t7_data50", data_o, 80'h50);
    tick();
    applyStimulus(1, 80'h52, 1, 1, 0, 0);
    checkOutput("t7_data51", data_o, 80'h51);
    tick();
    applyStimulus(0, 80'h0, 1, 1, 0, 0);
    checkOutput("t7_credits2", v_o, 0);
    checkOutput("t7_head52", data_o, 80'h52);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bsg_fsb_egress_credit_buffer.md
Name: bsg_fsb_egress_credit_buffer

Overview:
- Sits directly downstream of the test node client's FSB output channel (v/data/yumi, yumi late) and drives the FSB ring egress link.
- Buffers outgoing ring packets in a small FIFO.
- Enforces credit-based flow control toward the remote FSB receiver, so the ring never sees a packet the far side cannot absorb.
- Also provides the "yumi" handshake the client expects.

Parameters:
- ring_width_p, "inv", width of one FSB ring packet (80 in current chips).
- els_p, 4, FIFO depth in packets; must be ≥2.
- remote_credits_p, "inv", number of packets the remote receiver can hold; initial credit count, ≥1.

Ports:
- clk_i, input, 1, clock.
- reset_i, input, 1, reset.
- en_i, input, 1, accept enable; low = stop accepting new packets, keep draining.
- v_i, input, 1, upstream packet valid.
- data_i, input, ring_width_p, upstream packet.
- yumi_o, input→output, 1, upstream packet consumed this cycle.
- v_o, output, 1, egress packet valid.
- data_o, output, ring_width_p, egress packet (FIFO head).
- ready_i, input, 1, ring accepts packet this cycle.
- credit_i, input, 1, one-cycle pulse: remote freed one slot.
- credit_overflow_o, output, 1, sticky error: credit returned while counter already full.

Interface rule: one clock, clk_i; reset_i is synchronous and active-high.

Behaviour:
- Reset (reset_i high at a clk_i edge):
  - FIFO emptied; credit counter = remote_credits_p; credit_overflow_o = 0.
  - v_o = 0 and yumi_o = 0 while reset_i is high.
  - Any packets in flight mid-operation are discarded; credit_i pulses during reset are ignored.
- Counter width: credit counter is `BSG_SAFE_CLOG2(remote_credits_p+1) bits. FIFO pointers wrap modulo els_p; a full/empty disambiguation bit or occupancy counter (0..els_p) is required.
- Enqueue:
  - yumi_o = v_i & en_i & ~full & ~reset_i; purely combinational from v_i.
  - No combinational path from ready_i to yumi_o. When full, no enqueue occurs even if a dequeue happens the same cycle.
  - On yumi_o, data_i is written at the tail at the next edge.
- Dequeue:
  - v_o = ~empty & (credits != 0). data_o = head entry, stable while v_o & ~ready_i.
  - A send occurs when v_o & ready_i: head pops, credits decrement by 1.
  - Enqueue-to-v_o latency is 1 cycle minimum; no bypass from data_i to data_o.
- Simultaneous enqueue and dequeue when not full: occupancy unchanged; both occur.
- Credits:
  - credit_i with no send: credits + 1.
  - Send with no credit_i: credits − 1.
  - Both in the same cycle: unchanged.
  - Zero credits: v_o = 0 regardless of FIFO contents. A credit_i in that cycle allows v_o the next cycle.
  - credit_i with no send while credits == remote_credits_p: counter saturates (stays at max) and credit_overflow_o sets; it clears only on reset.
- en_i low: yumi_o = 0; FIFO continues to drain subject to credits. Toggling en_i never corrupts FIFO contents.
- Ordering: strict FIFO; no packet reordering or duplication.
- Assertions (simulation only): v_o must not drop without a send. Flag remote_credits_p < 1 or els_p < 2 at elaboration.

Optional Feature:
- Macro BSG_FSB_EGRESS_STATS_EN.
- When defined, adds two outputs:
  - sent_count_o, 32 bits: increments on each send.
  - credit_stall_o, 32 bits: increments each cycle with ~empty & (credits == 0).
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined: ports and counter logic are absent; behaviour is otherwise identical.

Test Plan (ring_width_p=80, els_p=4, remote_credits_p=2):
- Reset, then v_i=1 with data 0x1 → yumi_o=1 same cycle; v_o=1, data_o=0x1 next cycle; credits 2→1 on ready_i.
- Push 0xA, 0xB, 0xC with ready_i=1 and no credit_i → 0xA, 0xB sent in order; v_o=0 with 0xC queued. One credit_i pulse → 0xC sent the following cycle. With STATS: credit_stall_o counts the stalled cycles.
- ready_i=0, push 5 packets → yumi_o for the first 4 only, then 0 while full. Set ready_i=1 → packets drain in order.
- Same-cycle send and credit_i at credits=1 → credits stays 1.
- Separately, credit_i at credits=2 with no send → credit_overflow_o=1 and stays set until reset.
- en_i=0 with 2 queued packets and v_i=1 → yumi_o=0; both queued packets still emitted.
- Assert reset_i mid-drain with 3 queued → v_o=0 the next cycle; credits=2; old packets never appear.
